// File: rtl/mem_arb_pkg.sv
// Shared types, widths and the rotating-priority pick function for mem_req_arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned MAX_N   = 8;
  localparam int unsigned MAX_IDW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  // First valid requester scanning upward from ptr, wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0]   valid,
                                    input logic [MAX_IDW-1:0] ptr,
                                    input int unsigned        n);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      idx = (32'(ptr) + k) % n;
      if ((k < n) && !r.found && valid[idx]) begin
        r.found = 1'b1;
        r.idx   = MAX_IDW'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of granted requester IDs; head names the owner of the oldest burst.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A pop frees its slot in the same cycle, so a push into a full FIFO is accepted then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Burst-locking N:1 memory request arbiter with in-order response routing.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise requester 0 always wins.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned IDW        = $clog2(N)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        io_in_valid,
  output logic [N-1:0]        io_in_ready,
  input  logic [N*ADDR_W-1:0] io_in_bits_addr,
  input  logic [N*DATA_W-1:0] io_in_bits_data,
  input  logic [N*LEN_W-1:0]  io_in_bits_len,
  output logic                io_out_valid,
  input  logic                io_out_ready,
  output logic [ADDR_W-1:0]   io_out_bits_addr,
  output logic [DATA_W-1:0]   io_out_bits_data,
  output logic [IDW-1:0]      io_out_bits_id,
  output logic                io_out_bits_last,
  input  logic                io_resp_valid,
  output logic                io_resp_ready,
  input  logic [DATA_W-1:0]   io_resp_bits_data,
  input  logic                io_resp_bits_last,
  output logic [N-1:0]        io_rsp_valid,
  output logic [DATA_W-1:0]   io_rsp_bits_data
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [MAX_IDW-1:0] ptr_sel;
  pick_t              pick;
  logic               found;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     cur_id;
  logic [LEN_W-1:0]   cur_len;
  logic               grant_ok;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [IDW-1:0]     fifo_head;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  assign ptr_sel = MAX_IDW'(ptr_q);
`else
  assign ptr_sel = '0;
`endif

  // Winner search; the range test keeps every pick bit meaningful for small N.
  assign pick   = rr_pick(MAX_N'(io_in_valid), ptr_sel, N);
  assign found  = pick.found & ({1'b0, pick.idx} < (MAX_IDW + 1)'(N));
  assign winner = IDW'(pick.idx);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next state, request mux and handshakes; IDLE grants freshly, LOCK follows the owner.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    fifo_push   = 1'b0;
    grant_ok    = 1'b0;
    io_in_ready = '0;
    io_out_valid     = 1'b0;
    io_out_bits_last = 1'b0;

    cur_id  = (state_q == LOCK) ? owner_q : winner;
    cur_len = io_in_bits_len[32'(cur_id)*LEN_W +: LEN_W];
    io_out_bits_id   = cur_id;
    io_out_bits_addr = io_in_bits_addr[32'(cur_id)*ADDR_W +: ADDR_W];
    io_out_bits_data = io_in_bits_data[32'(cur_id)*DATA_W +: DATA_W];

    unique case (state_q)
      IDLE: begin
        grant_ok         = found & ~fifo_full;
        io_out_valid     = grant_ok;
        io_out_bits_last = (cur_len == '0);
        if (grant_ok && io_out_ready) begin
          fifo_push = 1'b1;
          cnt_d     = cur_len;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d     = IDW'((32'(winner) + 32'd1) % N);
`endif
          if (cur_len != '0) begin
            owner_d = winner;
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        grant_ok         = 1'b1;
        io_out_valid     = io_in_valid[owner_q];
        io_out_bits_last = (cnt_q == LEN_W'(1));
        if (io_out_valid && io_out_ready) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    io_in_ready[cur_id] = io_out_ready & grant_ok;
  end

  // Responses belong to the oldest outstanding burst; its last beat retires the ID.
  assign fifo_pop         = io_resp_valid & io_resp_bits_last & ~fifo_empty;
  assign io_resp_ready    = ~fifo_empty;
  assign io_rsp_valid     = (N'(1) << fifo_head) & {N{io_resp_valid & ~fifo_empty}};
  assign io_rsp_bits_data = io_resp_bits_data;

  arb_id_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (IDW)
  ) u_id_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .push_id (winner),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_mem_req_arbiter;

  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = 1;

  logic            clock;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*32-1:0] in_addr;
  logic [N*32-1:0] in_data;
  logic [N*4-1:0]  in_len;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_addr;
  logic [31:0]     out_data;
  logic [IDW-1:0]  out_id;
  logic            out_last;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic            resp_last;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_lock;
  int m_owner;
  int m_rem;
  int m_ptr;
  int m_q[$];

  mem_req_arbiter #(.N(N), .RESP_DEPTH(DEPTH), .IDW(IDW)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_in_valid       (in_valid),
    .io_in_ready       (in_ready),
    .io_in_bits_addr   (in_addr),
    .io_in_bits_data   (in_data),
    .io_in_bits_len    (in_len),
    .io_out_valid      (out_valid),
    .io_out_ready      (out_ready),
    .io_out_bits_addr  (out_addr),
    .io_out_bits_data  (out_data),
    .io_out_bits_id    (out_id),
    .io_out_bits_last  (out_last),
    .io_resp_valid     (resp_valid),
    .io_resp_ready     (resp_ready),
    .io_resp_bits_data (resp_data),
    .io_resp_bits_last (resp_last),
    .io_rsp_valid      (rsp_valid),
    .io_rsp_bits_data  (rsp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs();
    in_valid   = '0;
    in_addr    = '0;
    in_data    = '0;
    in_len     = '0;
    out_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_last  = 1'b0;
  endtask

  task automatic apply_reset();
    quiet_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic int ref_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    quiet_inputs();
    reset = 1'b0;
    resp_valid = 1'b1;
    resp_last  = 1'b1;
    tick();
    tick();
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++;
    if (resp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ready got %b want 0", resp_ready); end
    n_tests++;
    if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    n_tests++;
    if (in_ready !== '0) begin n_fail++; $display("FAIL reset_in_ready got %b want 00", in_ready); end
    reset = 1'b1;
    quiet_inputs();
    tick();
  endtask

  task automatic test_single_beat();
    apply_reset();
    in_valid     = 2'b01;
    in_addr[31:0] = 32'h0000_1000;
    in_data[31:0] = 32'hCAFE_0001;
    out_ready    = 1'b1;
    resp_valid   = 1'b1;
    resp_last    = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_id !== 1'b0 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL single_grant got v=%b id=%0d last=%b want v=1 id=0 last=1", out_valid, out_id, out_last);
    end
    n_tests++;
    if (in_ready !== 2'b01 || out_addr !== 32'h0000_1000 || out_data !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL single_mux got rdy=%b addr=%h data=%h want rdy=01 addr=00001000 data=cafe0001", in_ready, out_addr, out_data);
    end
    n_tests++;
    if (resp_ready !== 1'b0 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL single_no_bypass got resp_ready=%b rsp=%b want 0 00", resp_ready, rsp_valid);
    end
    tick();
    in_valid  = '0;
    resp_data = 32'h5A5A_0000;
    #1;
    n_tests++;
    if (resp_ready !== 1'b1 || rsp_valid !== 2'b01 || rsp_data !== 32'h5A5A_0000) begin
      n_fail++; $display("FAIL single_route got resp_ready=%b rsp=%b data=%h want 1 01 5a5a0000", resp_ready, rsp_valid, rsp_data);
    end
    tick();
    resp_valid = 1'b0;
    #1;
    n_tests++;
    if (resp_ready !== 1'b0) begin n_fail++; $display("FAIL single_pop got resp_ready=%b want 0", resp_ready); end
  endtask

  task automatic test_burst_lock();
    apply_reset();
    in_valid   = 2'b01;
    in_len[3:0] = 4'd3;
    in_len[7:4] = 4'd0;
    out_ready  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) in_valid = 2'b11;
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_id !== 1'b0 || out_last !== (b == 3) || in_ready !== 2'b01) begin
        n_fail++;
        $display("FAIL burst_beat%0d got v=%b id=%0d last=%b rdy=%b want v=1 id=0 last=%0d rdy=01",
                 b, out_valid, out_id, out_last, in_ready, (b == 3));
      end
      tick();
    end
    in_valid = 2'b10;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_id !== 1'b1 || out_last !== 1'b1 || in_ready !== 2'b10) begin
      n_fail++; $display("FAIL burst_next_grant got v=%b id=%0d last=%b rdy=%b want v=1 id=1 last=1 rdy=10",
                         out_valid, out_id, out_last, in_ready);
    end
    tick();
    in_valid = '0;
  endtask

  task automatic test_priority();
    int exp_id;
    apply_reset();
    in_valid  = 2'b11;
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_id = g % 2;
`else
      exp_id = 0;
`endif
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || int'(out_id) != exp_id) begin
        n_fail++; $display("FAIL priority_grant%0d got v=%b id=%0d want v=1 id=%0d", g, out_valid, out_id, exp_id);
      end
      tick();
    end
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 2'b00) begin
      n_fail++; $display("FAIL priority_full got v=%b rdy=%b want v=0 rdy=00", out_valid, in_ready);
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    in_valid       = 2'b01;
    in_len[3:0]    = 4'd2;
    in_addr[31:0]  = 32'hA000_0040;
    in_data[31:0]  = 32'h1234_5678;
    in_data[63:32] = 32'hDEAD_BEEF;
    out_ready      = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 2'b11;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_id !== 1'b0 || out_last !== 1'b0 || in_ready !== 2'b00 ||
          out_addr !== 32'hA000_0040 || out_data !== 32'h1234_5678) begin
        n_fail++; $display("FAIL stall%0d got v=%b id=%0d last=%b rdy=%b addr=%h data=%h want 1 0 0 00 a0000040 12345678",
                           s, out_valid, out_id, out_last, in_ready, out_addr, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (out_id !== 1'b0 || out_last !== 1'b0 || in_ready !== 2'b01) begin
      n_fail++; $display("FAIL stall_resume_beat2 got id=%0d last=%b rdy=%b want 0 0 01", out_id, out_last, in_ready);
    end
    tick();
    #1;
    n_tests++;
    if (out_id !== 1'b0 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL stall_resume_beat3 got id=%0d last=%b want 0 1", out_id, out_last);
    end
    tick();
    in_valid = '0;
  endtask

  task automatic test_fifo_full();
    apply_reset();
    in_valid    = 2'b10;
    in_len[7:4] = 4'd1;
    out_ready   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_id !== 1'b1 || out_last !== (c % 2 == 1)) begin
        n_fail++; $display("FAIL full_fill%0d got v=%b id=%0d last=%b want 1 1 %0d", c, out_valid, out_id, out_last, (c % 2 == 1));
      end
      tick();
    end
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 2'b00) begin
      n_fail++; $display("FAIL full_blocked got v=%b rdy=%b want 0 00", out_valid, in_ready);
    end
    resp_valid = 1'b1;
    resp_last  = 1'b1;
    #1;
    n_tests++;
    if (resp_ready !== 1'b1 || rsp_valid !== 2'b10 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_cycle got resp_ready=%b rsp=%b v=%b want 1 10 0", resp_ready, rsp_valid, out_valid);
    end
    tick();
    resp_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 2'b10) begin
      n_fail++; $display("FAIL full_regrant got v=%b rdy=%b want 1 10", out_valid, in_ready);
    end
    tick();
    in_valid = '0;
  endtask

  task automatic test_resp_routing();
    apply_reset();
    in_valid    = 2'b01;
    in_len[3:0] = 4'd1;
    in_len[7:4] = 4'd0;
    out_ready   = 1'b1;
    tick();
    tick();
    in_valid = 2'b10;
    tick();
    in_valid   = '0;
    out_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_last  = 1'b0;
    resp_data  = 32'h0000_00A1;
    #1;
    n_tests++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'h0000_00A1) begin
      n_fail++; $display("FAIL route_beat0 got rsp=%b data=%h want 01 000000a1", rsp_valid, rsp_data);
    end
    tick();
    resp_last = 1'b1;
    #1;
    n_tests++;
    if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL route_beat1 got rsp=%b want 01", rsp_valid); end
    tick();
    #1;
    n_tests++;
    if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL route_beat2 got rsp=%b want 10", rsp_valid); end
    tick();
    #1;
    n_tests++;
    if (resp_ready !== 1'b0 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL route_drained got resp_ready=%b rsp=%b want 0 00", resp_ready, rsp_valid);
    end
    resp_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    in_valid    = 2'b01;
    in_len[3:0] = 4'd3;
    out_ready   = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    in_valid = 2'b10;
    in_len[7:4] = 4'd0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_id !== 1'b1 || resp_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_lock got v=%b id=%0d resp_ready=%b want 1 1 0", out_valid, out_id, resp_ready);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int           w;
    int           exp_id;
    bit           exp_valid;
    bit           exp_last;
    bit           grant_ok;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;
    apply_reset();
    m_lock  = 1'b0;
    m_owner = 0;
    m_rem   = 0;
    m_ptr   = 0;
    m_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid   = N'($urandom);
      in_addr    = {$urandom, $urandom};
      in_data    = {$urandom, $urandom};
      in_len     = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      out_ready  = ($urandom_range(0, 3) != 0);
      resp_valid = $urandom_range(0, 1) == 1;
      resp_last  = $urandom_range(0, 1) == 1;
      resp_data  = $urandom;
      #1;
      if (!m_lock) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = ref_winner(in_valid, m_ptr);
`else
        w = ref_winner(in_valid, 0);
`endif
        grant_ok  = (w >= 0) && (m_q.size() < DEPTH);
        exp_valid = grant_ok;
        exp_id    = (w >= 0) ? w : 0;
        exp_last  = (in_len[exp_id*4 +: 4] == 4'd0);
      end else begin
        grant_ok  = 1'b1;
        exp_id    = m_owner;
        exp_valid = in_valid[m_owner];
        exp_last  = (m_rem == 1);
      end
      exp_ready = '0;
      if (grant_ok && out_ready) exp_ready[exp_id] = 1'b1;
      exp_rsp = '0;
      if (resp_valid && m_q.size() > 0) exp_rsp[m_q[0]] = 1'b1;

      n_tests++;
      if (out_valid !== exp_valid) begin
        n_fail++; $display("FAIL rand%0d_out_valid got %b want %b", cyc, out_valid, exp_valid);
      end
      if (exp_valid) begin
        n_tests++;
        if (int'(out_id) != exp_id || out_last !== exp_last ||
            out_addr !== in_addr[exp_id*32 +: 32] || out_data !== in_data[exp_id*32 +: 32]) begin
          n_fail++; $display("FAIL rand%0d_beat got id=%0d last=%b addr=%h want id=%0d last=%b addr=%h",
                             cyc, out_id, out_last, out_addr, exp_id, exp_last, in_addr[exp_id*32 +: 32]);
        end
      end
      n_tests++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand%0d_in_ready got %b want %b", cyc, in_ready, exp_ready);
      end
      n_tests++;
      if (resp_ready !== (m_q.size() > 0) || rsp_valid !== exp_rsp) begin
        n_fail++; $display("FAIL rand%0d_resp got ready=%b rsp=%b want ready=%0d rsp=%b",
                           cyc, resp_ready, rsp_valid, (m_q.size() > 0), exp_rsp);
      end

      // Advance the model on this cycle's handshakes
      if (resp_valid && resp_last && m_q.size() > 0) void'(m_q.pop_front());
      if (exp_valid && out_ready) begin
        if (!m_lock) begin
          m_q.push_back(exp_id);
          m_ptr = (exp_id + 1) % N;
          if (in_len[exp_id*4 +: 4] != 4'd0) begin
            m_lock  = 1'b1;
            m_owner = exp_id;
            m_rem   = int'(in_len[exp_id*4 +: 4]);
          end
        end else begin
          m_rem--;
          if (m_rem == 0) m_lock = 1'b0;
        end
      end
      tick();
    end
    quiet_inputs();
  endtask

  initial begin
    reset = 1'b0;
    quiet_inputs();
    test_reset();
    test_single_beat();
    test_burst_lock();
    test_priority();
    test_backpressure();
    test_fifo_full();
    test_resp_routing();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Burst-locking arbiter that shares one 32-bit memory request channel between N requesters, for example instruction-fetch and data-cache refill/writeback, and routes the response beats back to the owning requester. It sits between the cache-side request ports and the single bus/memory port. A grant is held for an entire burst. Each granted requester's ID is queued in order, so responses return to the right requester.

## Interface
- N, 2: number of requesters (2..8)
- RESP_DEPTH, 4: outstanding-burst ID FIFO depth (power of 2)
- IDW, $clog2(N): requester ID width (derived)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- io_in_valid  in  N  per-requester request valid
- io_in_ready  out  N  per-requester request ready
- io_in_bits_addr  in  N*32  request address, requester i at [32i+31:32i]
- io_in_bits_data  in  N*32  write data per beat
- io_in_bits_len  in  N*4  burst beats minus 1, sampled on the first beat only
- io_out_valid  out  1  bus request valid
- io_out_ready  in  1  bus request ready
- io_out_bits_addr / io_out_bits_data  out  32 / 32  selected beat
- io_out_bits_id  out  IDW  owner ID
- io_out_bits_last  out  1  final beat of the burst
- io_resp_valid  in  1  bus response valid
- io_resp_ready  out  1  response accepted
- io_resp_bits_data  in  32  response data
- io_resp_bits_last  in  1  final response beat of the oldest burst
- io_rsp_valid  out  N  per-requester response valid, one-hot
- io_rsp_bits_data  out  32  response data broadcast

## Operation
- FSM states:
  - IDLE: winner = highest-priority valid requester. The ID FIFO must not be full.
  - LOCK: owner register selects the requester.
- IDLE, winner exists:
  - io_out_valid=1. Mux the winner's addr/data; id=winner; last=(len==0).
  - On handshake: push winner ID to the FIFO and load beat counter = len.
  - If len!=0, latch owner and go to LOCK. Otherwise stay in IDLE.
- LOCK:
  - Pass through only the owner: io_out_valid=io_in_valid[owner]; last=(cnt==1).
  - Each handshake decrements cnt. The handshake with last=1 returns the FSM to IDLE.
  - The addr field is passed unchanged each beat; address increment is the bus's responsibility.
- io_in_ready[i] = io_out_ready & (i is the current winner/owner). It is 0 for all other requesters.
- Response routing:
  - io_resp_ready = FIFO not empty.
  - io_rsp_valid = onehot(FIFO head) & io_resp_valid & io_resp_ready.
  - The FIFO pops on a response handshake with io_resp_bits_last.
- FIFO full in IDLE: no grant; io_out_valid=0; all io_in_ready=0. A burst already in LOCK continues, because its ID was pushed at grant.
- Priority pointer updates on the grant handshake only: ptr = winner+1 mod N.

## Timing
- Reset values: state=IDLE, ptr=0, cnt=0, owner=0, FIFO empty. Outputs follow: io_out_valid=0 until an input is valid; io_resp_ready=0; io_rsp_valid=0.
- Request path is combinational, with zero added latency. Arbitration decision and in-to-out muxing happen in the same cycle.
- Winner is chosen only in IDLE. Changing io_in_valid during LOCK never changes the owner.
- Push and pop in the same cycle are legal, including when the FIFO is full (pop frees the slot in that cycle; push allowed) and when it is empty (a push does not bypass to the head in the same cycle).
- A response beat with the FIFO empty is not accepted: io_resp_ready=0.
- Reset asserted mid-burst: abort at the next edge. The FIFO is cleared, and outstanding responses are the bus's concern.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin priority starting from ptr.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 highest, consistent with the existing fixed-priority arbiters. The ptr register is removed.
- Locking, FIFO and routing are identical in both builds.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, LOCK}
  - localparams ADDR_W=32, DATA_W=32, LEN_W=4
  - function rr_pick(valid, ptr) returning the winner index and a found flag
- Sub-module arb_id_fifo (ID FIFO, RESP_DEPTH×IDW, push/pop/full/empty). All other logic lives in the top.

## Test plan
- Single beat: req0 valid, len=0, addr=0x1000, out_ready=1 → io_out_valid=1, id=0, last=1, in_ready[0]=1 same cycle; FIFO holds {0}.
- Burst lock: req0 len=3 granted; req1 raised on beat 2 → 4 beats id=0, last only on the 4th; req1 granted on the next cycle.
- Round robin (macro defined): both valid continuously, len=0 → grants alternate 0,1,0,1. Macro undefined → grants 0,0,0,0.
- Backpressure: out_ready=0 for 3 cycles mid-burst → cnt holds, owner holds, beat data stable.
- FIFO full: 4 bursts granted with no responses → 5th request sees in_ready=0 and io_out_valid=0. A response with last=1 → 5th grant on the following cycle.
- Response routing: bursts id0 (2 resp beats) then id1 → rsp_valid=01,01 then 10. Reset mid-LOCK → next cycle IDLE, io_resp_ready=0.
